// File: rtl/debounce_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : debounce_scheduler_if
// Description : Bundle of the scan strobe, raw inputs and debounced results
//               exchanged between a debounce_scheduler and its user.
//               master : drives CLK_en and SIGNAL, observes the results
//               slave  : the debounce engine itself
// Signals     : CLK_en     scan strobe, one CLK wide
//               SIGNAL     raw asynchronous input lines  [N_CHANNELS]
//               FILTERED   debounced levels              [N_CHANNELS]
//               CHANGE     one-CLK pulse on a reported flip
//               CHANNEL    index of last reported flip   [5]
//               NEW_VALUE  level of last reported flip
//               READY      settle period complete
// Revision    : 1.0 - initial release
// ============================================================================
interface debounce_scheduler_if #(
  parameter int N_CHANNELS = 4
) ();

  logic                  CLK_en;
  logic [N_CHANNELS-1:0] SIGNAL;
  logic [N_CHANNELS-1:0] FILTERED;
  logic                  CHANGE;
  logic [4:0]            CHANNEL;
  logic                  NEW_VALUE;
  logic                  READY;

  modport master (
    output CLK_en,
    output SIGNAL,
    input  FILTERED,
    input  CHANGE,
    input  CHANNEL,
    input  NEW_VALUE,
    input  READY
  );

  modport slave (
    input  CLK_en,
    input  SIGNAL,
    output FILTERED,
    output CHANGE,
    output CHANNEL,
    output NEW_VALUE,
    output READY
  );

endinterface
`default_nettype wire

// File: rtl/debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : debounce_scheduler
// Description : Time-multiplexed debounce engine. A single compare/count
//               datapath visits one input line per CLK_en strobe in
//               round-robin order. Each line owns a small counter of
//               consecutive disagreeing visits; when it reaches
//               DEBOUNCE_COUNT the debounced level flips. Flips are reported
//               as a one-CLK CHANGE pulse with channel index and new level,
//               but only once the engine has completed DEBOUNCE_COUNT full
//               scans since reset (READY).
// Ports       : CLK        system clock
//               nRESET     asynchronous active-low reset
//               bus.slave  CLK_en, SIGNAL in; FILTERED, CHANGE, CHANNEL,
//                          NEW_VALUE, READY out
// Parameters  : N_CHANNELS      number of scanned lines (2..32)
//               DEBOUNCE_COUNT  disagreeing visits needed to flip (>=1)
//               PRESET_VALUE    reset level of every debounced bit
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_scheduler #(
  parameter int N_CHANNELS     = 4,
  parameter int DEBOUNCE_COUNT = 5,
  parameter bit PRESET_VALUE   = 1'b1
) (
  input wire                  CLK,
  input wire                  nRESET,
  debounce_scheduler_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_cw = $clog2(DEBOUNCE_COUNT + 1);   // per-channel counter
  localparam int c_iw = $clog2(N_CHANNELS);           // scan index width

  localparam logic [c_cw-1:0]       c_cnt_last = c_cw'(DEBOUNCE_COUNT - 1);
  localparam logic [c_iw-1:0]       c_idx_last = c_iw'(N_CHANNELS - 1);
  localparam logic [N_CHANNELS-1:0] c_preset   = {N_CHANNELS{PRESET_VALUE}};

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [N_CHANNELS-1:0] r_sync_meta;
  logic [N_CHANNELS-1:0] r_sync;
  logic [c_iw-1:0]       r_idx;
  logic [c_cw-1:0]       r_cnt [N_CHANNELS];
  logic [N_CHANNELS-1:0] r_filtered;
  logic                  r_change;
  logic [4:0]            r_channel;
  logic                  r_new_value;
  state_t                r_state;
  logic [c_cw-1:0]       r_scans;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic            w_sel_sync;
  logic            w_sel_filt;
  logic [c_cw-1:0] w_sel_cnt;
  logic            w_differ;
  logic            w_at_last;
  logic            w_flip;
  logic            w_wrap;
  logic [c_cw-1:0] w_cnt_next;
  state_t          w_state_next;
  logic [c_cw-1:0] w_scans_next;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer, free-running on every CLK so that the sampled
  // value is already settled by the time the strobe visits the channel.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sync_meta <= c_preset;
      r_sync      <= c_preset;
    end else begin
      r_sync_meta <= bus.SIGNAL;
      r_sync      <= r_sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Shared datapath: select the channel under the scan index, compare it with
  // its debounced level and work out that channel's next counter value.
  // A counter that has reached DEBOUNCE_COUNT-1 on a disagreeing visit
  // returns to zero together with the flip, so it never exceeds that value.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_sync = r_sync[r_idx];
    w_sel_filt = r_filtered[r_idx];
    w_sel_cnt  = r_cnt[r_idx];
    w_differ   = w_sel_sync ^ w_sel_filt;
    w_at_last  = (w_sel_cnt == c_cnt_last);
    w_flip     = bus.CLK_en & w_differ & w_at_last;
    w_wrap     = bus.CLK_en & (r_idx == c_idx_last);
    w_cnt_next = '0;
    if (w_differ && !w_at_last) begin
      w_cnt_next = w_sel_cnt + c_cw'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel counter storage: only the channel currently under the scan
  // index is written back; every other counter holds its value.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_cnt
    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
        r_cnt[gi] <= '0;
      end else if (bus.CLK_en && (r_idx == c_iw'(gi))) begin
        r_cnt[gi] <= w_cnt_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan index, debounced levels and the change report.
  // The report is gated by the state register value before this edge, so a
  // flip landing on the very strobe that completes the settle period is
  // absorbed silently.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_idx       <= '0;
      r_filtered  <= c_preset;
      r_change    <= 1'b0;
      r_channel   <= 5'd0;
      r_new_value <= PRESET_VALUE;
    end else begin
      r_change <= 1'b0;
      if (bus.CLK_en) begin
        r_idx <= w_wrap ? '0 : (r_idx + c_iw'(1));
      end
      if (w_flip) begin
        r_filtered[r_idx] <= w_sel_sync;
        if (r_state == ST_RUN) begin
          r_change    <= 1'b1;
          r_channel   <= 5'(r_idx);
          r_new_value <= w_sel_sync;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Settle FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_SETTLE;
      r_scans <= '0;
    end else begin
      r_state <= w_state_next;
      r_scans <= w_scans_next;
    end
  end

  // --------------------------------------------------------------------------
  // Settle FSM: next state. Counts completed scans; the DEBOUNCE_COUNT-th
  // wrap of the scan index moves to RUN, which only a reset leaves.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_scans_next = r_scans;
    case (r_state)
      ST_SETTLE: begin
        if (w_wrap) begin
          if (r_scans == c_cnt_last) begin
            w_state_next = ST_RUN;
            w_scans_next = '0;
          end else begin
            w_scans_next = r_scans + c_cw'(1);
          end
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_SETTLE;
        w_scans_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.FILTERED  = r_filtered;
  assign bus.CHANGE    = r_change;
  assign bus.CHANNEL   = r_channel;
  assign bus.NEW_VALUE = r_new_value;
  assign bus.READY     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_scheduler
// Description : Self-checking bench for debounce_scheduler (4 channels,
//               count 5, preset 1). A behavioural model tracks, per channel,
//               the run of disagreeing visits and the number of completed
//               scans, and is compared with the DUT on every falling CLK edge.
//               Directed scenarios pin the model with literal expectations,
//               then randomized strobes and bouncy inputs exercise it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_scheduler;

  localparam int N   = 4;
  localparam int DC  = 5;
  localparam bit PRE = 1'b1;

  logic CLK = 1'b0;
  logic nRESET;

  debounce_scheduler_if #(.N_CHANNELS(N)) bus ();

  debounce_scheduler #(
    .N_CHANNELS     (N),
    .DEBOUNCE_COUNT (DC),
    .PRESET_VALUE   (PRE)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm, input int arg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event (arg %0d) at %0t", nm, arg, $time);
  endtask

  // ---------------------------------------------------------------- strobes
  int en_mode = 0;   // 0: every 16 CLK, 1: continuous, 2: random
  int div     = 0;
  always begin
    @(posedge CLK);
    #2;
    if (nRESET !== 1'b1) begin
      div        = 0;
      bus.CLK_en = 1'b0;
    end else begin
      case (en_mode)
        0: begin
          div++;
          if (div == 16) begin
            div        = 0;
            bus.CLK_en = 1'b1;
          end else begin
            bus.CLK_en = 1'b0;
          end
        end
        1:       bus.CLK_en = 1'b1;
        default: bus.CLK_en = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // ------------------------------------------------------------------ model
  logic [N-1:0] m_filt, h1, h2, s_used;
  int  m_streak [N];
  int  m_idx, m_scans, strobes, last_serv, m_channel;
  bit  m_ready, m_change, m_newval;

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      m_filt    = {N{PRE}};
      h1        = {N{PRE}};
      h2        = {N{PRE}};
      for (int c = 0; c < N; c++) m_streak[c] = 0;
      m_idx     = 0;
      m_scans   = 0;
      strobes   = 0;
      last_serv = -1;
      m_ready   = 1'b0;
      m_change  = 1'b0;
      m_channel = 0;
      m_newval  = PRE;
    end else begin
      // value seen by the engine this edge is the input from two edges ago
      s_used    = h2;
      h2        = h1;
      h1        = bus.SIGNAL;
      m_change  = 1'b0;
      last_serv = -1;
      if (bus.CLK_en === 1'b1) begin
        int i;
        i         = m_idx;
        strobes++;
        last_serv = i;
        if (s_used[i] != m_filt[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DC) begin
            m_filt[i]   = s_used[i];
            m_streak[i] = 0;
            if (m_ready) begin
              m_change  = 1'b1;
              m_channel = i;
              m_newval  = s_used[i];
            end
          end
        end else begin
          m_streak[i] = 0;
        end
        m_idx = (m_idx + 1) % N;
        if (m_idx == 0) begin
          m_scans++;
          if (m_scans >= DC) m_ready = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- compare
  bit chk_en   = 1'b0;
  int n_pulses = 0;
  int pulse_q[$];

  always @(negedge CLK) begin
    if (chk_en) begin
      check("filtered",  32'(bus.FILTERED),  32'(m_filt));
      check("change",    32'(bus.CHANGE),    32'(m_change));
      check("ready",     32'(bus.READY),     32'(m_ready));
      check("channel",   32'(bus.CHANNEL),   32'(m_channel));
      check("new_value", 32'(bus.NEW_VALUE), 32'(m_newval));
      if (bus.CHANGE === 1'b1) begin
        n_pulses++;
        pulse_q.push_back(int'(bus.CHANNEL));
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic wait_visit(input int ch, input int n);
    bit seen;
    for (int v = 0; v < n; v++) begin
      seen = 1'b0;
      for (int k = 0; k < 4000 && !seen; k++) begin
        @(negedge CLK);
        if (last_serv == ch) seen = 1'b1;
      end
      if (!seen) timeout_fail("wait_visit", ch);
    end
  endtask

  task automatic wait_ready(output int at_strobe);
    bit seen;
    seen      = 1'b0;
    at_strobe = -1;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge CLK);
      if (bus.READY === 1'b1) begin
        seen      = 1'b1;
        at_strobe = strobes;
      end
    end
    if (!seen) timeout_fail("wait_ready", 0);
  endtask

  task automatic pulse_reset(input logic [N-1:0] sig);
    @(posedge CLK);
    #2;
    bus.SIGNAL = sig;
    nRESET     = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    nRESET = 1'b1;
  endtask

  // --------------------------------------------------------------- watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------- scenarios
  initial begin
    int at;
    int p0;
    nRESET     = 1'b0;
    bus.SIGNAL = '1;
    repeat (2) @(posedge CLK);
    #2;
    chk_en = 1'b1;
    check("rst_filtered",  32'(bus.FILTERED),  32'hF);
    check("rst_ready",     32'(bus.READY),     32'h0);
    check("rst_change",    32'(bus.CHANGE),    32'h0);
    check("rst_channel",   32'(bus.CHANNEL),   32'h0);
    check("rst_new_value", 32'(bus.NEW_VALUE), 32'h1);
    nRESET = 1'b1;

    // 1: settle period ends exactly on the 20th strobe, silently
    p0 = n_pulses;
    wait_ready(at);
    check("t1_ready_strobe", 32'(at), 32'd20);
    @(negedge CLK);
    check("t1_no_pulses", 32'(n_pulses - p0), 32'd0);

    // 2: ch2 held low flips on its 5th visit
    p0 = n_pulses;
    wait_visit(1, 1);
    bus.SIGNAL[2] = 1'b0;
    wait_visit(2, 4);
    check("t2_before_flip", 32'(bus.FILTERED), 32'hF);
    wait_visit(2, 1);
    @(negedge CLK);
    check("t2_filtered", 32'(bus.FILTERED),  32'b1011);
    check("t2_pulses",   32'(n_pulses - p0), 32'd1);
    check("t2_channel",  32'(bus.CHANNEL),   32'd2);
    check("t2_newval",   32'(bus.NEW_VALUE), 32'd0);

    // 3: 3-visit glitch on ch1 is rejected, a 5-visit low flips it
    p0 = n_pulses;
    wait_visit(0, 1);
    bus.SIGNAL[1] = 1'b0;
    wait_visit(1, 3);
    bus.SIGNAL[1] = 1'b1;
    wait_visit(1, 3);
    check("t3_glitch_filt",   32'(bus.FILTERED),  32'b1011);
    check("t3_glitch_pulses", 32'(n_pulses - p0), 32'd0);
    wait_visit(0, 1);
    bus.SIGNAL[1] = 1'b0;
    wait_visit(1, 5);
    @(negedge CLK);
    check("t3_filtered", 32'(bus.FILTERED),  32'b1001);
    check("t3_pulses",   32'(n_pulses - p0), 32'd1);
    check("t3_channel",  32'(bus.CHANNEL),   32'd1);

    // 6: async reset while ch3 has 3 disagreeing visits
    wait_visit(2, 1);
    bus.SIGNAL[3] = 1'b0;
    wait_visit(3, 3);
    #3;
    nRESET = 1'b0;
    #1;
    check("t6_async_filt",  32'(bus.FILTERED),  32'hF);
    check("t6_async_ready", 32'(bus.READY),     32'h0);
    check("t6_async_chg",   32'(bus.CHANGE),    32'h0);
    check("t6_async_chan",  32'(bus.CHANNEL),   32'h0);
    check("t6_async_nv",    32'(bus.NEW_VALUE), 32'h1);
    @(posedge CLK);
    repeat (2) @(posedge CLK);
    #2;
    nRESET = 1'b1;
    p0 = n_pulses;
    wait_visit(3, 4);
    check("t6_ch3_hold", 32'(bus.FILTERED[3]), 32'd1);
    wait_visit(3, 1);
    @(negedge CLK);
    check("t6_filtered", 32'(bus.FILTERED),  32'b0001);
    check("t6_ready",    32'(bus.READY),     32'd1);
    check("t6_pulses",   32'(n_pulses - p0), 32'd0);

    // 4: all lines fall together -> four pulses in scan order
    wait_visit(3, 1);
    bus.SIGNAL = 4'b1111;
    wait_visit(3, 5);
    @(negedge CLK);
    check("t4_restore", 32'(bus.FILTERED), 32'hF);
    p0 = n_pulses;
    pulse_q.delete();
    bus.SIGNAL = 4'b0000;
    wait_visit(3, 5);
    @(negedge CLK);
    check("t4_pulses",   32'(n_pulses - p0), 32'd4);
    check("t4_filtered", 32'(bus.FILTERED),  32'h0);
    if (pulse_q.size() == 4) begin
      for (int k = 0; k < 4; k++) check("t4_order", 32'(pulse_q[k]), 32'(k));
    end else begin
      check("t4_queue_size", 32'(pulse_q.size()), 32'd4);
    end

    // 5: reset with every input opposite to preset -> settles silently
    pulse_reset(4'b0000);
    p0 = n_pulses;
    wait_ready(at);
    @(negedge CLK);
    check("t5_ready_strobe", 32'(at),            32'd20);
    check("t5_filtered",     32'(bus.FILTERED),  32'h0);
    check("t5_pulses",       32'(n_pulses - p0), 32'd0);

    // random strobes, slowly bouncing inputs
    en_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 149) == 0) bus.SIGNAL[b] = ~bus.SIGNAL[b];
    end

    // random reset, then continuous strobing with faster bouncing
    @(negedge CLK);
    #2;
    nRESET = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    nRESET  = 1'b1;
    en_mode = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 59) == 0) bus.SIGNAL[b] = ~bus.SIGNAL[b];
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
